// File: rtl/sl_event_reporter.sv
// Round-robin event reporter: latches per-channel change events and serialises
// them as CHANNEL/STATUS/CONFIG/DATA words onto a single FIFO write port.
module sl_event_reporter #(
    parameter int TX_COUNT = 1,
    parameter int RX_COUNT = 1,
    parameter int CH_W     = $clog2((TX_COUNT > RX_COUNT) ? TX_COUNT : RX_COUNT) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    report_en,
    input  logic [TX_COUNT-1:0]     config_changed_tx,
    input  logic [TX_COUNT-1:0]     status_changed_tx,
    input  logic [16*TX_COUNT-1:0]  rd_config_tx,
    input  logic [TX_COUNT-1:0]     rd_status_tx,
    input  logic [RX_COUNT-1:0]     config_changed_rx,
    input  logic [RX_COUNT-1:0]     status_changed_rx,
    input  logic [RX_COUNT-1:0]     data_changed_rx,
    input  logic [16*RX_COUNT-1:0]  rd_config_rx,
    input  logic [RX_COUNT-1:0]     rd_status_rx,
    input  logic [32*RX_COUNT-1:0]  rd_data_rx,
    input  logic                    fifo_write_full,
    output logic [33:0]             fifo_write_data,
    output logic                    fifo_write_inc,
    output logic                    busy
);
    localparam int N  = TX_COUNT + RX_COUNT;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE, SCAN, SEND_CH, SEND_STATUS, SEND_CONFIG, SEND_DATA
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] ptr_reg, ptr_next;
    logic [SW-1:0] cur_reg, cur_next;
    logic [SW-1:0] last_reg, last_next;
    logic          last_v_reg, last_v_next;
    logic [N-1:0]  st_pend_reg, cfg_pend_reg, dat_pend_reg;
    logic [N-1:0]  st_evt, cfg_evt, dat_evt;
    logic [N-1:0]  st_clr, cfg_clr, dat_clr;
    logic [N-1:0]  any_pend, status_bit;
    logic [15:0]   cfg_val  [N];
    logic [31:0]   data_val [N];
    logic [33:0]   fifo_write_data_reg, word;
    logic          fifo_write_inc_reg, push;
    logic          found;
    logic [SW-1:0] pick;
    logic [31:0]   ch_payload;

    // Flatten TX and RX channels into one slot space: TX first, RX after.
    genvar gi;
    generate
        for (gi = 0; gi < TX_COUNT; gi++) begin : g_tx
            assign st_evt[gi]     = status_changed_tx[gi];
            assign cfg_evt[gi]    = config_changed_tx[gi];
            assign dat_evt[gi]    = 1'b0;
            assign status_bit[gi] = rd_status_tx[gi];
            assign cfg_val[gi]    = rd_config_tx[16*gi +: 16];
            assign data_val[gi]   = '0;
        end
        for (gi = 0; gi < RX_COUNT; gi++) begin : g_rx
            assign st_evt[TX_COUNT+gi]     = status_changed_rx[gi];
            assign cfg_evt[TX_COUNT+gi]    = config_changed_rx[gi];
            assign dat_evt[TX_COUNT+gi]    = data_changed_rx[gi];
            assign status_bit[TX_COUNT+gi] = rd_status_rx[gi];
            assign cfg_val[TX_COUNT+gi]    = rd_config_rx[16*gi +: 16];
            assign data_val[TX_COUNT+gi]   = rd_data_rx[32*gi +: 32];
        end
    endgenerate

    assign any_pend = st_pend_reg | cfg_pend_reg | dat_pend_reg;

    function automatic state_t first_payload(input logic st, input logic cfg, input logic dat);
        if (st)       return SEND_STATUS;
        else if (cfg) return SEND_CONFIG;
        else if (dat) return SEND_DATA;
        else          return IDLE;
    endfunction

    // First pending slot at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && any_pend[(int'(ptr_reg) + k) % N]) begin
                found = 1'b1;
                pick  = SW'((int'(ptr_reg) + k) % N);
            end
        end
    end

    always_comb begin
        ch_payload = '0;
        if (int'(cur_reg) >= TX_COUNT) begin
            ch_payload[0]      = 1'b1;
            ch_payload[CH_W:1] = CH_W'(int'(cur_reg) - TX_COUNT);
        end else begin
            ch_payload[CH_W:1] = CH_W'(int'(cur_reg));
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cur_next    = cur_reg;
        last_next   = last_reg;
        last_v_next = last_v_reg;
        push        = 1'b0;
        word        = fifo_write_data_reg;
        st_clr      = '0;
        cfg_clr     = '0;
        dat_clr     = '0;
        case (state_reg)
            IDLE: if (report_en && |any_pend) state_next = SCAN;
            SCAN: begin
                if (!found) begin
                    state_next = IDLE;
                end else begin
                    cur_next = pick;
                    ptr_next = (int'(pick) == N - 1) ? '0 : pick + SW'(1);
                    if (last_v_reg && last_reg == pick)
                        state_next = first_payload(st_pend_reg[pick], cfg_pend_reg[pick], dat_pend_reg[pick]);
                    else
                        state_next = SEND_CH;
                end
            end
            SEND_CH: if (!fifo_write_full) begin
                push        = 1'b1;
                word        = {2'd3, ch_payload};
                last_next   = cur_reg;
                last_v_next = 1'b1;
                state_next  = first_payload(st_pend_reg[cur_reg], cfg_pend_reg[cur_reg], dat_pend_reg[cur_reg]);
            end
            SEND_STATUS: if (!fifo_write_full) begin
                push            = 1'b1;
                word            = {2'd2, 31'b0, status_bit[cur_reg]};
                st_clr[cur_reg] = 1'b1;
                state_next      = first_payload(1'b0, cfg_pend_reg[cur_reg], dat_pend_reg[cur_reg]);
            end
            SEND_CONFIG: if (!fifo_write_full) begin
                push             = 1'b1;
                word             = {2'd0, 16'b0, cfg_val[cur_reg]};
                cfg_clr[cur_reg] = 1'b1;
                state_next       = first_payload(1'b0, 1'b0, dat_pend_reg[cur_reg]);
            end
            SEND_DATA: if (!fifo_write_full) begin
                push             = 1'b1;
                word             = {2'd1, data_val[cur_reg]};
                dat_clr[cur_reg] = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            ptr_reg             <= '0;
            cur_reg             <= '0;
            last_reg            <= '0;
            last_v_reg          <= 1'b0;
            st_pend_reg         <= '0;
            cfg_pend_reg        <= '0;
            dat_pend_reg        <= '0;
            fifo_write_inc_reg  <= 1'b0;
            fifo_write_data_reg <= '0;
        end else begin
            state_reg          <= state_next;
            ptr_reg            <= ptr_next;
            cur_reg            <= cur_next;
            last_reg           <= last_next;
            last_v_reg         <= last_v_next;
            // A new event pulse outranks the clear from a simultaneous push.
            st_pend_reg        <= (st_pend_reg  & ~st_clr)  | st_evt;
            cfg_pend_reg       <= (cfg_pend_reg & ~cfg_clr) | cfg_evt;
            dat_pend_reg       <= (dat_pend_reg & ~dat_clr) | dat_evt;
            fifo_write_inc_reg <= push;
            if (push) fifo_write_data_reg <= word;
        end
    end

    assign fifo_write_data = fifo_write_data_reg;
    assign fifo_write_inc  = fifo_write_inc_reg;
    assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_sl_event_reporter.sv
// Self-checking bench for sl_event_reporter (2 TX + 2 RX): directed scenarios
// followed by randomized event bursts checked against a report-level model.
module tb_sl_event_reporter;
    logic        clk = 1'b0;
    logic        rst, report_en, fifo_write_full;
    logic [1:0]  config_changed_tx, status_changed_tx, rd_status_tx;
    logic [31:0] rd_config_tx, rd_config_rx;
    logic [1:0]  config_changed_rx, status_changed_rx, data_changed_rx, rd_status_rx;
    logic [63:0] rd_data_rx;
    logic [33:0] fifo_write_data;
    logic        fifo_write_inc, busy;

    int checks = 0, failures = 0, cyc = 0, pop_cyc = 0;
    logic [33:0] got_q[$];
    int          got_cyc[$];
    logic [33:0] exp_q[$];
    int m_ptr, m_last;
    logic m_lv;
    logic [3:0] ev_st, ev_cfg, ev_dat;

    sl_event_reporter #(.TX_COUNT(2), .RX_COUNT(2)) dut (
        .clk(clk), .rst(rst), .report_en(report_en),
        .config_changed_tx(config_changed_tx), .status_changed_tx(status_changed_tx),
        .rd_config_tx(rd_config_tx), .rd_status_tx(rd_status_tx),
        .config_changed_rx(config_changed_rx), .status_changed_rx(status_changed_rx),
        .data_changed_rx(data_changed_rx), .rd_config_rx(rd_config_rx),
        .rd_status_rx(rd_status_rx), .rd_data_rx(rd_data_rx),
        .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data),
        .fifo_write_inc(fifo_write_inc), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_write_inc === 1'b1) begin
            got_q.push_back(fifo_write_data);
            got_cyc.push_back(cyc);
            $display("push cyc=%0d word=%09h", cyc, fifo_write_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [33:0] exp);
        logic [33:0] w;
        w = 'x;
        pop_cyc = -1;
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            pop_cyc = got_cyc.pop_front();
        end
        chk(tag, 64'(w), 64'(exp));
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
    endtask

    // Wait for three consecutive idle cycles; optionally toggle full randomly.
    task automatic drain(input string tag, input logic rand_full);
        int idle_cnt = 0;
        for (int i = 0; i < 400 && idle_cnt < 3; i++) begin
            if (rand_full) fifo_write_full = ($urandom_range(0, 2) == 0);
            tick(1);
            idle_cnt = busy ? 0 : idle_cnt + 1;
        end
        fifo_write_full = 1'b0;
        tick(3);
        chk({tag, "_drain"}, 64'(idle_cnt), 64'd3);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_mon();
    endtask

    function automatic logic [33:0] ch_word(input int s);
        int rx = (s >= 2) ? 1 : 0;
        int loc = s - 2 * rx;
        return {2'd3, 32'(loc * 2 + rx)};
    endfunction

    // Report-level model: serve every pending slot in ring order from ptr.
    task automatic model_burst();
        int start = m_ptr;
        logic served = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int s = (start + k) % 4;
            if (ev_st[s] | ev_cfg[s] | ev_dat[s]) begin
                if (!(m_lv && m_last == s)) exp_q.push_back(ch_word(s));
                if (ev_st[s])
                    exp_q.push_back({2'd2, 31'b0, (s < 2) ? rd_status_tx[s] : rd_status_rx[s-2]});
                if (ev_cfg[s])
                    exp_q.push_back({2'd0, 16'b0, (s < 2) ? rd_config_tx[16*s +: 16] : rd_config_rx[16*(s-2) +: 16]});
                if (ev_dat[s])
                    exp_q.push_back({2'd1, rd_data_rx[32*(s-2) +: 32]});
                m_last = s;
                m_lv = 1'b1;
                served = 1'b1;
            end
        end
        if (served) m_ptr = (m_last + 1) % 4;
    endtask

    initial begin
        int c0, nrep, wait_n;
        rst = 1'b1; report_en = 1'b1; fifo_write_full = 1'b0;
        config_changed_tx = '0; status_changed_tx = '0; rd_status_tx = '0; rd_config_tx = '0;
        config_changed_rx = '0; status_changed_rx = '0; data_changed_rx = '0;
        rd_config_rx = '0; rd_status_rx = '0; rd_data_rx = '0;
        tick(3);
        chk("rst_inc", 64'(fifo_write_inc), 64'd0);
        chk("rst_data", 64'(fifo_write_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(1);

        // TX ch1 status report
        rd_status_tx = 2'b10; status_changed_tx = 2'b10; tick(1); status_changed_tx = '0;
        drain("t1", 1'b0);
        pop_chk("t1_ch", 34'h3_0000_0002); c0 = pop_cyc;
        pop_chk("t1_st", 34'h2_0000_0001);
        chk("t1_consec", 64'(pop_cyc - c0), 64'd1);
        chk("t1_empty", 64'(got_q.size()), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_hold", 64'(fifo_write_data), 64'h2_0000_0001);

        // RX ch0 config + data, status skipped
        rd_config_rx = 32'h0000_A5A5; rd_data_rx = 64'h0000_0000_DEAD_BEEF;
        config_changed_rx = 2'b01; data_changed_rx = 2'b01; tick(1);
        config_changed_rx = '0; data_changed_rx = '0;
        drain("t2", 1'b0);
        pop_chk("t2_ch", 34'h3_0000_0001);
        pop_chk("t2_cfg", 34'h0_0000_A5A5);
        pop_chk("t2_dat", 34'h1_DEAD_BEEF);
        chk("t2_empty", 64'(got_q.size()), 64'd0);

        // Same channel twice: second report has no CHANNEL word
        rd_status_tx = 2'b01; status_changed_tx = 2'b01; tick(1); status_changed_tx = '0;
        tick(6); rd_status_tx = 2'b00; tick(3);
        status_changed_tx = 2'b01; tick(1); status_changed_tx = '0;
        drain("t4", 1'b0);
        pop_chk("t4_ch", 34'h3_0000_0000);
        pop_chk("t4_st1", 34'h2_0000_0001);
        pop_chk("t4_st2", 34'h2_0000_0000);
        chk("t4_empty", 64'(got_q.size()), 64'd0);

        // Backpressure during SEND_CONFIG; value sampled at push
        fifo_write_full = 1'b1; rd_config_tx = 32'h0000_1111;
        config_changed_tx = 2'b01; tick(1); config_changed_tx = '0;
        tick(3);
        chk("t5_busy", 64'(busy), 64'd1);
        rd_config_tx = 32'h0000_2222;
        tick(2);
        chk("t5_no_push", 64'(got_q.size()), 64'd0);
        chk("t5_no_inc", 64'(fifo_write_inc), 64'd0);
        fifo_write_full = 1'b0; tick(1);
        chk("t5_inc", 64'(fifo_write_inc), 64'd1);
        drain("t5", 1'b0);
        pop_chk("t5_cfg", 34'h0_0000_2222);
        chk("t5_empty", 64'(got_q.size()), 64'd0);

        // New pulse in the push cycle keeps the pending bit set
        fifo_write_full = 1'b1; rd_config_tx = 32'h0000_3333;
        config_changed_tx = 2'b01; tick(1); config_changed_tx = '0;
        tick(4);
        fifo_write_full = 1'b0; config_changed_tx = 2'b01; tick(1); config_changed_tx = '0;
        drain("t6", 1'b0);
        pop_chk("t6_cfg1", 34'h0_0000_3333);
        pop_chk("t6_cfg2", 34'h0_0000_3333);
        chk("t6_empty", 64'(got_q.size()), 64'd0);

        // Reset mid-report on RX ch1
        rd_status_rx = 2'b10; rd_config_rx = 32'hBEEF_0000; rd_data_rx = 64'h1234_5678_0000_0000;
        status_changed_rx = 2'b10; config_changed_rx = 2'b10; data_changed_rx = 2'b10; tick(1);
        status_changed_rx = '0; config_changed_rx = '0; data_changed_rx = '0;
        wait_n = 0;
        while (got_q.size() == 0 && wait_n < 30) begin tick(1); wait_n++; end
        chk("t7_started", 64'(got_q.size() != 0), 64'd1);
        pop_chk("t7_ch", 34'h3_0000_0003);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("t7_inc", 64'(fifo_write_inc), 64'd0);
        chk("t7_data", 64'(fifo_write_data), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        tick(2); clear_mon();
        status_changed_rx = 2'b10; tick(1); status_changed_rx = '0;
        drain("t7", 1'b0);
        pop_chk("t7_ch2", 34'h3_0000_0003);
        pop_chk("t7_st", 34'h2_0000_0001);
        chk("t7_empty", 64'(got_q.size()), 64'd0);

        // report_en low holds the scheduler in IDLE
        report_en = 1'b0;
        status_changed_tx = 2'b01; tick(1); status_changed_tx = '0;
        tick(8);
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_none", 64'(got_q.size()), 64'd0);
        report_en = 1'b1;
        drain("en", 1'b0);
        pop_chk("en_ch", 34'h3_0000_0000);
        pop_chk("en_st", 34'h2_0000_0000);
        chk("en_empty", 64'(got_q.size()), 64'd0);

        // Fairness: slots 0 and 2 pulsed every cycle
        reset_pulse();
        rd_status_tx = 2'b00; rd_status_rx = 2'b01;
        status_changed_tx = 2'b01; status_changed_rx = 2'b01;
        tick(40);
        status_changed_tx = '0; status_changed_rx = '0;
        drain("rr", 1'b0);
        chk("rr_even", 64'(got_q.size() % 2), 64'd0);
        nrep = got_q.size() / 2;
        chk("rr_enough", 64'(nrep >= 8), 64'd1);
        for (int r = 0; r < nrep; r++) begin
            pop_chk($sformatf("rr_ch%0d", r), (r % 2 == 0) ? 34'h3_0000_0000 : 34'h3_0000_0001);
            pop_chk($sformatf("rr_st%0d", r), (r % 2 == 0) ? 34'h2_0000_0000 : 34'h2_0000_0001);
        end

        // Randomized bursts against the report-level model
        reset_pulse();
        m_ptr = 0; m_last = 0; m_lv = 1'b0;
        for (int b = 0; b < 25; b++) begin
            rd_status_tx = 2'($urandom); rd_status_rx = 2'($urandom);
            rd_config_tx = $urandom; rd_config_rx = $urandom;
            rd_data_rx = {$urandom, $urandom};
            ev_st = 4'($urandom); ev_cfg = 4'($urandom); ev_dat = {2'($urandom), 2'b00};
            status_changed_tx = ev_st[1:0]; status_changed_rx = ev_st[3:2];
            config_changed_tx = ev_cfg[1:0]; config_changed_rx = ev_cfg[3:2];
            data_changed_rx = ev_dat[3:2];
            tick(1);
            status_changed_tx = '0; status_changed_rx = '0;
            config_changed_tx = '0; config_changed_rx = '0; data_changed_rx = '0;
            drain($sformatf("rnd%0d", b), 1'b1);
            exp_q.delete();
            model_burst();
            foreach (exp_q[i]) pop_chk($sformatf("rnd%0d_w%0d", b, i), exp_q[i]);
            chk($sformatf("rnd%0d_empty", b), 64'(got_q.size()), 64'd0);
            clear_mon();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
